// File: rtl/tcb_gpio_pkg.sv
// Shared definitions for the TCB GPIO controller: register map and bus response type.
// The response carries a 32-bit read word, so the controller's bus data width is 32.
package tcb_gpio_pkg;

  localparam int unsigned BUS_DW = 32;

  // Register offsets, selected by word address bits [3:2].
  typedef enum logic [1:0] {
    REG_OUT = 2'd0,
    REG_ENA = 2'd1,
    REG_INP = 2'd2,
    REG_RSV = 2'd3
  } reg_sel_e;

  typedef struct packed {
    logic [BUS_DW-1:0] rdt;
    logic              err;
  } rsp_t;

endpackage

// File: rtl/tcb_gpio_sync.sv
// Multi-stage flop chain that brings the asynchronous pad inputs into the clk domain.
// A depth of zero turns the block into a plain wire.
module tcb_gpio_sync #(
  parameter int unsigned GW   = 32,
  parameter int unsigned SYNC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [GW-1:0] d,
  output logic [GW-1:0] q
);

  if (SYNC == 0) begin : g_bypass
    assign q = d;
  end else begin : g_chain
    logic [GW-1:0] stage [SYNC];

    // NOTE: the stage array is reset, unlike a RAM, so INP reads zero after reset instead of X.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < SYNC; i++) stage[i] <= '0;
      end else begin
        stage[0] <= d;
        for (int i = 1; i < SYNC; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[SYNC-1];
  end

endmodule

// File: rtl/tcb_gpio_ctl.sv
// GPIO peripheral on the TCB bus: OUT/ENA read-write registers, synchronized INP,
// always-ready slave with a registered one-cycle read/error response.
module tcb_gpio_ctl
  import tcb_gpio_pkg::*;
#(
  parameter int unsigned AW   = 22,
  parameter int unsigned DW   = BUS_DW,
  parameter int unsigned GW   = 32,
  parameter int unsigned SYNC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bus_vld,
  input  logic          bus_wen,
  input  logic [AW-1:0] bus_adr,
  input  logic [DW/8-1:0] bus_ben,
  input  logic [DW-1:0] bus_wdt,
  output logic [DW-1:0] bus_rdt,
  output logic          bus_err,
  output logic          bus_rdy,
  output logic [GW-1:0] gpio_o,
  output logic [GW-1:0] gpio_e,
  input  logic [GW-1:0] gpio_i
);

  localparam int unsigned BW = DW / 8;

  logic          xfer;
  reg_sel_e      sel;
  logic [DW-1:0] wmask;
  logic [DW-1:0] out_ext;
  logic [DW-1:0] ena_ext;
  logic [GW-1:0] out_q, out_d;
  logic [GW-1:0] ena_q, ena_d;
  logic [GW-1:0] inp_s;
  rsp_t          rsp_q, rsp_d;
  logic          adr_unused;

  assign bus_rdy    = 1'b1;
  assign xfer       = bus_vld & bus_rdy;
  assign sel        = reg_sel_e'(bus_adr[3:2]);
  assign adr_unused = ^{bus_adr[AW-1:4], bus_adr[1:0]};

  tcb_gpio_sync #(
    .GW   (GW),
    .SYNC (SYNC)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gpio_i),
    .q   (inp_s)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    wmask = '0;
    for (int k = 0; k < BW; k++) wmask[8*k +: 8] = {8{bus_ben[k]}};

    out_ext = DW'(out_q);
    ena_ext = DW'(ena_q);
    out_d   = out_q;
    ena_d   = ena_q;

    if (xfer && bus_wen) begin
      if (sel == REG_OUT) out_d = GW'((out_ext & ~wmask) | (bus_wdt & wmask));
      if (sel == REG_ENA) ena_d = GW'((ena_ext & ~wmask) | (bus_wdt & wmask));
    end
  end

  // Read data holds between reads; the error flag lasts one cycle per offending transfer.
  always_comb begin
    rsp_d.rdt = rsp_q.rdt;
    rsp_d.err = 1'b0;

    if (xfer) begin
      if (bus_wen) begin
        rsp_d.err = (sel == REG_INP) || (sel == REG_RSV);
      end else begin
        unique case (sel)
          REG_OUT: rsp_d.rdt = BUS_DW'(out_q);
          REG_ENA: rsp_d.rdt = BUS_DW'(ena_q);
          REG_INP: rsp_d.rdt = BUS_DW'(inp_s);
          REG_RSV: begin
            rsp_d.rdt = '0;
            rsp_d.err = 1'b1;
          end
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
      ena_q <= '0;
      rsp_q <= '0;
    end else begin
      out_q <= out_d;
      ena_q <= ena_d;
      rsp_q <= rsp_d;
    end
  end

  assign gpio_o  = out_q;
  assign gpio_e  = ena_q;
  assign bus_rdt = DW'(rsp_q.rdt);
  assign bus_err = rsp_q.err;

endmodule

// File: tb/tb_tcb_gpio_ctl.sv
// Directed bench for tcb_gpio_ctl: expected bus responses are queued when a transfer
// is driven and compared when the registered response appears one cycle later.
module tb_tcb_gpio_ctl;

  localparam int unsigned AW   = 22;
  localparam int unsigned DW   = 32;
  localparam int unsigned GW   = 32;
  localparam int unsigned SYNC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          bus_vld;
  logic          bus_wen;
  logic [AW-1:0] bus_adr;
  logic [DW/8-1:0] bus_ben;
  logic [DW-1:0] bus_wdt;
  logic [DW-1:0] bus_rdt;
  logic          bus_err;
  logic          bus_rdy;
  logic [GW-1:0] gpio_o;
  logic [GW-1:0] gpio_e;
  logic [GW-1:0] gpio_i;

  tcb_gpio_ctl #(
    .AW   (AW),
    .DW   (DW),
    .GW   (GW),
    .SYNC (SYNC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus_vld (bus_vld),
    .bus_wen (bus_wen),
    .bus_adr (bus_adr),
    .bus_ben (bus_ben),
    .bus_wdt (bus_wdt),
    .bus_rdt (bus_rdt),
    .bus_err (bus_err),
    .bus_rdy (bus_rdy),
    .gpio_o  (gpio_o),
    .gpio_e  (gpio_e),
    .gpio_i  (gpio_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rdt;
    logic        err;
    bit          chk_rdt;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] out_m;
  logic [31:0] ena_m;
  logic [31:0] inp_old;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdt,
                                        input logic [3:0] ben);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (ben[k]) r[8*k +: 8] = wdt[8*k +: 8];
    return r;
  endfunction

  // Drives one transfer just after a rising edge and checks its response after the next one.
  task automatic xfer(input string tag, input logic wen, input logic [AW-1:0] adr,
                      input logic [3:0] ben, input logic [31:0] wdt,
                      input logic [31:0] exp_rdt, input logic exp_err, input bit chk_rdt);
    exp_t e;
    bus_vld = 1'b1;
    bus_wen = wen;
    bus_adr = adr;
    bus_ben = ben;
    bus_wdt = wdt;
    e = '{tag, exp_rdt, exp_err, chk_rdt};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_err"}, 32'(bus_err), 32'(e.err));
      if (e.chk_rdt) check({e.tag, "_rdt"}, bus_rdt, e.rdt);
    end
  endtask

  task automatic idle();
    bus_vld = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b0;
    bus_vld = 1'b0;
    bus_wen = 1'b0;
    bus_adr = '0;
    bus_ben = '0;
    bus_wdt = '0;
    gpio_i  = '0;
    out_m   = '0;
    ena_m   = '0;

    repeat (4) @(posedge clk);
    #1;
    check("rst_gpio_o", gpio_o, 32'h0);
    check("rst_gpio_e", gpio_e, 32'h0);
    check("rst_rdt", bus_rdt, 32'h0);
    check("rst_err", 32'(bus_err), 32'h0);
    check("rst_rdy", 32'(bus_rdy), 32'h1);
    rst = 1'b1;
    idle();

    // Full-word write to OUT, then read it back.
    out_m = merge(out_m, 32'hA5A5_1234, 4'b1111);
    xfer("wr_out", 1'b1, 22'h0, 4'b1111, 32'hA5A5_1234, 32'h0, 1'b0, 1'b0);
    check("gpio_o_full", gpio_o, out_m);
    xfer("rd_out", 1'b0, 22'h0, 4'b1111, 32'h0, 32'hA5A5_1234, 1'b0, 1'b1);

    // Sparse byte enables on ENA; reads ignore ben and adr[1:0].
    ena_m = merge(ena_m, 32'hFFFF_FFFF, 4'b0101);
    xfer("wr_ena", 1'b1, 22'h4, 4'b0101, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
    check("gpio_e_ben", gpio_e, 32'h00FF_00FF);
    xfer("rd_ena", 1'b0, 22'h4, 4'b0000, 32'h0, 32'h00FF_00FF, 1'b0, 1'b1);
    xfer("rd_ena_unal", 1'b0, 22'h7, 4'b0001, 32'h0, 32'h00FF_00FF, 1'b0, 1'b1);
    idle();

    // Input synchronizer: the first SYNC reads after the change still see the old pins.
    inp_old = gpio_i;
    gpio_i  = 32'h5555_AAAA;
    for (int i = 0; i < SYNC; i++)
      xfer("rd_inp_stale", 1'b0, 22'h8, 4'b1111, 32'h0, inp_old, 1'b0, 1'b1);
    xfer("rd_inp_new", 1'b0, 22'h8, 4'b1111, 32'h0, 32'h5555_AAAA, 1'b0, 1'b1);
    idle();

    // Illegal write and reserved read: one-cycle error, no state change.
    xfer("wr_inp", 1'b1, 22'h8, 4'b1111, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    check("wr_inp_gpio_o", gpio_o, out_m);
    check("wr_inp_gpio_e", gpio_e, ena_m);
    idle();
    check("wr_inp_err_clr", 32'(bus_err), 32'h0);
    xfer("rd_rsv", 1'b0, 22'hC, 4'b1111, 32'h0, 32'h0, 1'b1, 1'b1);
    idle();
    check("rd_rsv_err_clr", 32'(bus_err), 32'h0);
    check("rd_rsv_rdt_hold", bus_rdt, 32'h0);
    xfer("wr_rsv", 1'b1, 22'hC, 4'b1111, 32'h1234_5678, 32'h0, 1'b1, 1'b0);
    xfer("rd_inp_kept", 1'b0, 22'h8, 4'b1111, 32'h0, 32'h5555_AAAA, 1'b0, 1'b1);
    xfer("rd_out_kept", 1'b0, 22'h0, 4'b1111, 32'h0, out_m, 1'b0, 1'b1);

    // Back-to-back write/read pairs with no idle cycles.
    out_m = 32'h1;
    xfer("b2b_wr1", 1'b1, 22'h0, 4'b1111, 32'h1, 32'h0, 1'b0, 1'b0);
    xfer("b2b_rd1", 1'b0, 22'h0, 4'b1111, 32'h0, 32'h1, 1'b0, 1'b1);
    out_m = 32'h2;
    xfer("b2b_wr2", 1'b1, 22'h0, 4'b1111, 32'h2, 32'h0, 1'b0, 1'b0);
    xfer("b2b_rd2", 1'b0, 22'h0, 4'b1111, 32'h0, 32'h2, 1'b0, 1'b1);

    // Single middle byte into OUT.
    out_m = merge(out_m, 32'hEEEE_CDEE, 4'b0010);
    xfer("wr_out_b1", 1'b1, 22'h0, 4'b0010, 32'hEEEE_CDEE, 32'h0, 1'b0, 1'b0);
    check("gpio_o_b1", gpio_o, 32'h0000_CD02);
    xfer("rd_out_b1", 1'b0, 22'h0, 4'b1111, 32'h0, out_m, 1'b0, 1'b1);
    idle();

    // Reset asserted while a write is pending: it is dropped, outputs clear at once.
    bus_vld = 1'b1;
    bus_wen = 1'b1;
    bus_adr = 22'h0;
    bus_ben = 4'b1111;
    bus_wdt = 32'hDEAD_BEEF;
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_gpio_o", gpio_o, 32'h0);
    check("mid_rst_rdt", bus_rdt, 32'h0);
    @(posedge clk);
    #1;
    check("mid_rst_dropped", gpio_o, 32'h0);
    rst     = 1'b1;
    bus_vld = 1'b0;
    out_m   = '0;
    ena_m   = '0;
    xfer("rd_inp_post_rst", 1'b0, 22'h8, 4'b1111, 32'h0, 32'h0, 1'b0, 1'b1);
    xfer("rd_ena_post_rst", 1'b0, 22'h4, 4'b1111, 32'h0, ena_m, 1'b0, 1'b1);
    idle();

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
